// File: rtl/bbox_pkg.sv
// Shared types and constants for the bounding-box datapath (sipo, boundingbox, piso).
// BBOX_PISO_PARITY_EN appends an even-parity bit to every transmitted frame.
package bbox_pkg;

  localparam int COORD_W = 16;
  localparam int FRAC_W  = 6;
  localparam int BBOX_W  = 4 * COORD_W;

  typedef struct packed {
    logic [COORD_W-1:0] ymax;
    logic [COORD_W-1:0] ymin;
    logic [COORD_W-1:0] xmax;
    logic [COORD_W-1:0] xmin;
  } bbox_t;

  typedef enum logic {IDLE, SHIFT} piso_state_e;

  // Serial frame length for a given payload width, including the optional parity bit.
  function automatic int frame_len(input int width);
`ifdef BBOX_PISO_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/bbox_piso_tx_if.sv
// Handshake and serial-link bundle between boundingbox, the PISO transmitter and the host.
interface bbox_piso_tx_if #(
  parameter int WIDTH = 64
);
  logic             en;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out;
  logic             out_valid;
  logic             out_first;
  logic             out_last;

  modport master (
    output en, in_valid, in_data,
    input  in_ready, out, out_valid, out_first, out_last
  );

  modport slave (
    input  en, in_valid, in_data,
    output in_ready, out, out_valid, out_first, out_last
  );
endinterface

// File: rtl/bbox_piso_tx_buf.sv
// One-entry holding register with a valid/ready handshake, independent of the shift enable.
module piso_buf #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             take,
  output logic             in_ready,
  output logic [WIDTH-1:0] data,
  output logic             full
);

  logic accept;

  assign accept   = in_valid && !full;
  assign in_ready = !full;

  // A drain and a refill in the same cycle leave the buffer full with the new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else begin
      if (take) begin
        full <= 1'b0;
      end
      if (accept) begin
        full <= 1'b1;
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/bbox_piso_tx.sv
// LSB-first parallel-in serial-out transmitter for packed bounding-box results.
// Define BBOX_PISO_PARITY_EN to append an even-parity bit after the payload.
module bbox_piso_tx
  import bbox_pkg::*;
#(
  parameter int WIDTH = BBOX_W,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  bbox_piso_tx_if.slave       bus
);

  localparam int FRAME_LEN = frame_len(WIDTH);

  piso_state_e          state;
  logic [FRAME_LEN-1:0] shreg;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     buf_data;
  logic                 full;
  logic                 take;
  logic                 frame_done;
  logic [FRAME_LEN-1:0] next_frame;

  piso_buf #(.WIDTH(WIDTH)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bus.in_valid),
    .in_data  (bus.in_data),
    .take     (take),
    .in_ready (bus.in_ready),
    .data     (buf_data),
    .full     (full)
  );

`ifdef BBOX_PISO_PARITY_EN
  assign next_frame = {^buf_data, buf_data};
`else
  assign next_frame = buf_data;
`endif

  // cnt counts bits already emitted, so a frame is finished once it equals FRAME_LEN.
  assign frame_done = (state == IDLE) || (cnt == CNT_W'(FRAME_LEN));
  assign take       = bus.en && full && frame_done;

  // Loading emits bit 0 in the same cycle, giving one-cycle latency and gap-free frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      shreg         <= '0;
      cnt           <= '0;
      bus.out       <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_first <= 1'b0;
      bus.out_last  <= 1'b0;
    end else if (!bus.en) begin
      bus.out       <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_first <= 1'b0;
      bus.out_last  <= 1'b0;
    end else if (take) begin
      state         <= SHIFT;
      shreg         <= next_frame >> 1;
      cnt           <= CNT_W'(1);
      bus.out       <= next_frame[0];
      bus.out_valid <= 1'b1;
      bus.out_first <= 1'b1;
      bus.out_last  <= (FRAME_LEN == 1);
    end else if ((state == SHIFT) && !frame_done) begin
      shreg         <= shreg >> 1;
      cnt           <= cnt + CNT_W'(1);
      bus.out       <= shreg[0];
      bus.out_valid <= 1'b1;
      bus.out_first <= 1'b0;
      bus.out_last  <= (cnt == CNT_W'(FRAME_LEN - 1));
    end else begin
      state         <= IDLE;
      cnt           <= '0;
      bus.out       <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_first <= 1'b0;
      bus.out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bbox_piso_tx.sv
// Directed scoreboard bench for bbox_piso_tx: frames are reassembled from the serial link
// and compared against words pushed when offered (parity model follows BBOX_PISO_PARITY_EN).
module tb_bbox_piso_tx;

  localparam int WIDTH     = 64;
  localparam int FRAME_LEN = bbox_pkg::frame_len(WIDTH);

  logic clk = 1'b0;
  logic rst = 1'b1;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] sb[$];
  int first_cyc[$];
  int last_cyc[$];

  logic [FRAME_LEN-1:0] got;
  int   idx      = 0;
  bit   in_frame = 1'b0;
  int   cyc      = 0;
  int   frames   = 0;
  logic last_bit = 1'b0;

  bbox_piso_tx_if #(.WIDTH(WIDTH)) bus ();

  bbox_piso_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [64:0] frame_model(input logic [WIDTH-1:0] w);
`ifdef BBOX_PISO_PARITY_EN
    return {^w, w};
`else
    return {1'b0, w};
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Offer one word and hold it until accepted; the scoreboard entry is pushed at offer time.
  task automatic applyStimulus(input logic [WIDTH-1:0] w);
    int tmo = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (!bus.in_ready && tmo < 500) begin
      tick();
      tmo++;
    end
    checkOutput("accept_timeout", 65'(tmo >= 500), 65'd0);
    sb.push_back(w);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int tmo = 0;
    while ((sb.size() != 0 || in_frame) && tmo < 2000) begin
      tick();
      tmo++;
    end
    checkOutput("drain_timeout", 65'(tmo >= 2000), 65'd0);
  endtask

  task automatic waitBit(input int bit_no);
    int tmo = 0;
    while (!(in_frame && idx == bit_no) && tmo < 500) begin
      tick();
      tmo++;
    end
    checkOutput("bit_wait_timeout", 65'(tmo >= 500), 65'd0);
  endtask

  // Serial monitor: reassembles each frame and compares it against the scoreboard head.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      in_frame = 1'b0;
      idx      = 0;
    end else if (bus.out_valid) begin
      if (bus.out_first) begin
        checkOutput("first_mid_frame", 65'(in_frame), 65'd0);
        in_frame = 1'b1;
        idx      = 0;
        got      = '0;
        first_cyc.push_back(cyc);
      end
      if (in_frame && idx < FRAME_LEN) got[idx] = bus.out;
      idx++;
      if (bus.out_last) begin
        checkOutput("frame_len", 65'(idx), 65'(FRAME_LEN));
        last_bit = bus.out;
        last_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          checkOutput("unexpected_frame", 65'(got), 65'd0);
        end else begin
          checkOutput("payload", 65'(got), frame_model(sb.pop_front()));
        end
        frames++;
        in_frame = 1'b0;
      end
    end
  end

  initial begin
    int vcount;
    got          = '0;
    bus.en       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset values
    repeat (3) tick();
    checkOutput("rst_in_ready",  65'(bus.in_ready),  65'd1);
    checkOutput("rst_out_valid", 65'(bus.out_valid), 65'd0);
    checkOutput("rst_out",       65'(bus.out),       65'd0);
    checkOutput("rst_out_first", 65'(bus.out_first), 65'd0);
    checkOutput("rst_out_last",  65'(bus.out_last),  65'd0);
    rst    = 1'b0;
    bus.en = 1'b1;
    tick();

    // Single frame with latency check
    $display("[TB] single frame");
    applyStimulus(64'h0000_0000_0000_0001);
    tick();
    checkOutput("latency_first", 65'(bus.out_first), 65'd1);
    checkOutput("latency_bit0",  65'(bus.out),       65'd1);
    waitDrain();
`ifdef BBOX_PISO_PARITY_EN
    checkOutput("single_parity", 65'(last_bit), 65'd1);
`else
    checkOutput("single_last_bit", 65'(last_bit), 65'd0);
`endif
    repeat (3) tick();

    // Back-to-back frames offered on consecutive cycles
    $display("[TB] back-to-back");
    first_cyc.delete();
    last_cyc.delete();
    applyStimulus(64'hFFC0_003F_AAAA_5555);
    applyStimulus(64'h0040_0080_00C0_0100);
    waitDrain();
    checkOutput("b2b_count", 65'(first_cyc.size()), 65'd2);
    if (first_cyc.size() == 2 && last_cyc.size() == 2)
      checkOutput("b2b_no_gap", 65'(first_cyc[1]), 65'(last_cyc[0] + 1));
    repeat (3) tick();

    // Backpressure with three queued words
    $display("[TB] backpressure");
    vcount = frames;
    applyStimulus(64'h1111_2222_3333_4444);
    applyStimulus(64'h5555_6666_7777_8888);
    checkOutput("bp_in_ready_low", 65'(bus.in_ready), 65'd0);
    applyStimulus(64'h9999_AAAA_BBBB_CCCC);
    waitDrain();
    checkOutput("bp_frames", 65'(frames - vcount), 65'd3);
    repeat (3) tick();

    // Enable stall at bit 20
    $display("[TB] en stall");
    applyStimulus(64'hDEAD_BEEF_0123_4567);
    waitBit(20);
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall_out_valid", 65'(bus.out_valid), 65'd0);
    end
    checkOutput("stall_idx_hold", 65'(idx), 65'd20);
    bus.en = 1'b1;
    waitDrain();
    repeat (3) tick();

    // Asynchronous reset mid-frame with the buffer full
    $display("[TB] reset mid-frame");
    applyStimulus(64'hCAFE_F00D_1234_5678);
    applyStimulus(64'h0BAD_0BAD_0BAD_0BAD);
    waitBit(30);
    checkOutput("rst_mid_buf_full", 65'(bus.in_ready), 65'd0);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_out_valid", 65'(bus.out_valid), 65'd0);
    checkOutput("rst_mid_in_ready",  65'(bus.in_ready),  65'd1);
    sb.delete();
    repeat (2) tick();
    rst = 1'b0;
    vcount = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.out_valid) vcount++;
    end
    checkOutput("rst_residual_bits", 65'(vcount), 65'd0);
    applyStimulus(64'h0123_4567_89AB_CDEF);
    waitDrain();

`ifdef BBOX_PISO_PARITY_EN
    // Parity bit values
    $display("[TB] parity");
    applyStimulus(64'h0000_0000_0000_0003);
    waitDrain();
    checkOutput("parity_even", 65'(last_bit), 65'd0);
    applyStimulus(64'h0000_0000_0000_0007);
    waitDrain();
    checkOutput("parity_odd", 65'(last_bit), 65'd1);
`endif

    repeat (5) tick();
    checkOutput("sb_empty", 65'(sb.size()), 65'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
